// File: rtl/cross_4k_rmerge.sv
// rtl/cross_4k_rmerge.sv - merges split read sub-bursts back into one burst per original AR
// Optional master-side 2-entry register slice: define CROSS_4K_RMERGE_REG_EN.
module cross_4k_rmerge #(
  parameter int W_ID   = 4,
  parameter int W_DATA = 32,
  parameter int W_RESP = 2,
  parameter int W_PCS  = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              info_valid,
  input  logic [W_PCS-1:0]  info_pcs,
  output logic              info_ready,
  input  logic [W_ID-1:0]   s_axi_rid,
  input  logic [W_DATA-1:0] s_axi_rdata,
  input  logic [W_RESP-1:0] s_axi_rresp,
  input  logic              s_axi_rlast,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready,
  output logic [W_ID-1:0]   m_axi_rid,
  output logic [W_DATA-1:0] m_axi_rdata,
  output logic [W_RESP-1:0] m_axi_rresp,
  output logic              m_axi_rlast,
  output logic              m_axi_rvalid,
  input  logic              m_axi_rready
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [W_PCS-1:0] info_mem [DEPTH];
  logic [W_PCS-1:0] pcs_cnt, head_raw, head_pcs;
  logic             empty, full, push, pop, xfer, final_sub, merged_last;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign info_ready  = !full;
  assign push        = info_valid && !full;
  assign head_raw    = info_mem[rd_ptr[AW-1:0]];
  // A record of 0 sub-bursts cannot occur in practice; treat it as a single one.
  assign head_pcs    = (head_raw == '0) ? W_PCS'(1) : head_raw;
  assign final_sub   = (pcs_cnt == head_pcs - W_PCS'(1));
  assign xfer        = s_axi_rvalid && s_axi_rready;
  assign pop         = xfer && s_axi_rlast && final_sub;
  assign merged_last = !empty && s_axi_rlast && final_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pcs_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        pcs_cnt <= '0;
      end else if (xfer && s_axi_rlast) begin
        pcs_cnt <= pcs_cnt + W_PCS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) info_mem[wr_ptr[AW-1:0]] <= info_pcs;
  end

`ifdef CROSS_4K_RMERGE_REG_EN
  localparam int PW = W_ID + W_DATA + W_RESP + 1;

  logic [PW-1:0] sl0, sl1, sl_d;
  logic [1:0]    sl_cnt;
  logic          sl_pop;

  assign sl_d         = {s_axi_rid, s_axi_rdata, s_axi_rresp, merged_last};
  assign sl_pop       = (sl_cnt != 2'd0) && m_axi_rready;
  assign s_axi_rready = !empty && (sl_cnt != 2'd2);
  assign m_axi_rvalid = (sl_cnt != 2'd0);
  assign {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast} = sl0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sl0    <= '0;
      sl1    <= '0;
      sl_cnt <= 2'd0;
    end else begin
      case ({xfer, sl_pop})
        2'b10: begin
          if (sl_cnt == 2'd0) sl0 <= sl_d;
          else                sl1 <= sl_d;
          sl_cnt <= sl_cnt + 2'd1;
        end
        2'b01: begin
          sl0    <= sl1;
          sl_cnt <= sl_cnt - 2'd1;
        end
        2'b11: begin
          if (sl_cnt == 2'd1) begin
            sl0 <= sl_d;
          end else begin
            sl0 <= sl1;
            sl1 <= sl_d;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign s_axi_rready = !empty && m_axi_rready;
  assign m_axi_rvalid = !empty && s_axi_rvalid;
  assign m_axi_rid    = s_axi_rid;
  assign m_axi_rdata  = s_axi_rdata;
  assign m_axi_rresp  = s_axi_rresp;
  assign m_axi_rlast  = merged_last;
`endif

endmodule

// File: tb/tb_cross_4k_rmerge.sv
// tb/tb_cross_4k_rmerge.sv - randomized and directed self-checking bench for cross_4k_rmerge
module tb_cross_4k_rmerge;

  localparam int W_ID = 4, W_DATA = 32, W_RESP = 2, W_PCS = 4, DEPTH = 8;

  logic              clk = 0;
  logic              rst;
  logic              info_valid;
  logic [W_PCS-1:0]  info_pcs;
  logic              info_ready;
  logic [W_ID-1:0]   s_axi_rid;
  logic [W_DATA-1:0] s_axi_rdata;
  logic [W_RESP-1:0] s_axi_rresp;
  logic              s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [W_ID-1:0]   m_axi_rid;
  logic [W_DATA-1:0] m_axi_rdata;
  logic [W_RESP-1:0] m_axi_rresp;
  logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

  cross_4k_rmerge #(.W_ID(W_ID), .W_DATA(W_DATA), .W_RESP(W_RESP), .W_PCS(W_PCS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .info_valid(info_valid), .info_pcs(info_pcs), .info_ready(info_ready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: queue of outstanding AR records and sub-bursts finished for the head one.
  int q[$];
  int done_sub;
  bit chk_en;

  // Observations of the master side, reset per directed test.
  int nb, nlast, last_pos;
  logic [W_DATA-1:0] rx_q[$];
  bit last_xfer;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    int  hp;
    bit  ne, fin, xfer, can_push;
    @(negedge clk);
    ne  = (q.size() > 0);
    hp  = ne ? ((q[0] == 0) ? 1 : q[0]) : 1;
    fin = ne && (done_sub == hp - 1);
    if (chk_en) begin
      chk("info_ready", info_ready, q.size() < DEPTH);
      chk("s_rready",   s_axi_rready, ne && m_axi_rready);
      chk("m_rvalid",   m_axi_rvalid, ne && s_axi_rvalid);
      chk("m_rlast",    m_axi_rlast,  s_axi_rlast && fin);
      chk("m_rid",      m_axi_rid,    s_axi_rid);
      chk("m_rdata",    m_axi_rdata,  s_axi_rdata);
      chk("m_rresp",    m_axi_rresp,  s_axi_rresp);
    end
    last_xfer = s_axi_rvalid && s_axi_rready;
    if (m_axi_rvalid && m_axi_rready) begin
      nb++;
      rx_q.push_back(m_axi_rdata);
      if (m_axi_rlast) begin
        nlast++;
        last_pos = nb;
      end
    end
    if (rst) begin
      q.delete();
      done_sub = 0;
    end else begin
      can_push = info_valid && (q.size() < DEPTH);
      xfer = ne && s_axi_rvalid && m_axi_rready;
      if (xfer && s_axi_rlast) begin
        if (fin) begin
          void'(q.pop_front());
          done_sub = 0;
        end else begin
          done_sub++;
        end
      end
      if (can_push) q.push_back(int'(info_pcs));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    nb = 0; nlast = 0; last_pos = 0;
    rx_q.delete();
  endtask

  task automatic idle_inputs();
    info_valid = 0; info_pcs = 0;
    s_axi_rvalid = 0; s_axi_rlast = 0;
    s_axi_rid = 0; s_axi_rdata = 0; s_axi_rresp = 0;
    m_axi_rready = 1;
  endtask

  task automatic push_rec(int pcs);
    info_valid = 1; info_pcs = W_PCS'(pcs);
    tick();
    info_valid = 0;
  endtask

  task automatic beat(bit last);
    s_axi_rvalid = 1; s_axi_rlast = last;
    s_axi_rdata = $urandom; s_axi_rid = W_ID'($urandom); s_axi_rresp = W_RESP'($urandom);
    tick();
    s_axi_rvalid = 0; s_axi_rlast = 0;
  endtask

  initial begin
    logic [W_DATA-1:0] d5 [3];
    int k, cyc;
    done_sub = 0; chk_en = 0;
    idle_inputs();
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    tick();
    chk("reset_s_rready", s_axi_rready, 1'b0);
    chk("reset_m_rvalid", m_axi_rvalid, 1'b0);
    chk("reset_info_ready", info_ready, 1'b1);

    // pcs=1, 4-beat burst
    clear_obs();
    push_rec(1);
    for (int i = 1; i <= 4; i++) beat(i == 4);
    chk("t1_beats", nb, 4);
    chk("t1_last_pos", last_pos, 4);
    chk("t1_empty_rready", s_axi_rready, 1'b0);

    // pcs=2, sub-bursts of 2 and 3 beats
    clear_obs();
    push_rec(2);
    beat(0); beat(1);
    chk("t2_pcs_cnt_mid", dut.pcs_cnt, 1);
    beat(0); beat(0); beat(1);
    chk("t2_beats", nb, 5);
    chk("t2_nlast", nlast, 1);
    chk("t2_last_pos", last_pos, 5);

    // beat waiting on an empty FIFO
    clear_obs();
    s_axi_rvalid = 1; s_axi_rlast = 1; s_axi_rdata = 32'hCAFE_0001;
    repeat (3) tick();
    chk("t3_stalled", nb, 0);
    info_valid = 1; info_pcs = 1;
    tick();
    info_valid = 0;
    chk("t3_push_cycle", nb, 0);
    tick();
    s_axi_rvalid = 0; s_axi_rlast = 0;
    chk("t3_passed", nb, 1);
    chk("t3_data", rx_q.size() == 1 && rx_q[0] == 32'hCAFE_0001, 1'b1);

    // fill to full, then pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) push_rec(1);
    chk("t4_full", info_ready, 1'b0);
    info_valid = 1; info_pcs = 1;
    s_axi_rvalid = 1; s_axi_rlast = 1;
    tick();
    s_axi_rvalid = 0; s_axi_rlast = 0;
    chk("t4_after_pop", info_ready, 1'b1);
    tick();
    info_valid = 0;
    chk("t4_refull", info_ready, 1'b0);
    s_axi_rvalid = 1; s_axi_rlast = 1;
    repeat (DEPTH) tick();
    s_axi_rvalid = 0; s_axi_rlast = 0;
    chk("t4_drained", s_axi_rready, 1'b0);

    // pcs=3 of 1-beat sub-bursts with toggling master ready
    clear_obs();
    for (int i = 0; i < 3; i++) d5[i] = $urandom;
    push_rec(3);
    k = 0; cyc = 0;
    while (k < 3 && cyc < 40) begin
      s_axi_rvalid = 1; s_axi_rlast = 1; s_axi_rdata = d5[k];
      m_axi_rready = (cyc % 2 == 0);
      tick();
      if (last_xfer) k++;
      cyc++;
    end
    s_axi_rvalid = 0; s_axi_rlast = 0; m_axi_rready = 1;
    chk("t5_done", k, 3);
    chk("t5_beats", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_order", (i < rx_q.size()) ? rx_q[i] : 'x, d5[i]);
    chk("t5_nlast", nlast, 1);
    chk("t5_last_pos", last_pos, 3);

    // reset between the two sub-bursts of a pcs=2 record
    push_rec(2);
    beat(1);
    chk("t6_pcs_cnt_mid", dut.pcs_cnt, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_pcs_cnt", dut.pcs_cnt, 0);
    chk("t6_s_rready", s_axi_rready, 1'b0);
    chk("t6_info_ready", info_ready, 1'b1);

    // randomized traffic against the reference
    for (int c = 0; c < 4000; c++) begin
      rst          = ($urandom_range(0, 999) == 0);
      info_valid   = ($urandom_range(0, 3) == 0);
      info_pcs     = W_PCS'($urandom);
      s_axi_rvalid = ($urandom_range(0, 3) != 0);
      s_axi_rlast  = ($urandom_range(0, 2) == 0);
      s_axi_rid    = W_ID'($urandom);
      s_axi_rdata  = $urandom;
      s_axi_rresp  = W_RESP'($urandom);
      m_axi_rready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cross_4k_rmerge.md
Name: cross_4k_rmerge

Overview:
- Read-response merger downstream of the 4 KB burst splitter (cross_4k_if).
- For every original AR accepted from the master, the splitter pushes the number of sub-bursts it issued.
- This block consumes slave R beats in order and suppresses RLAST on all but the final sub-burst, so the master sees one burst per AR.
- R data, ID and RESP pass through unchanged; the block sits between the slave-side R channel and the master-side R channel.

Parameters:
- W_ID, 4, read ID width
- W_DATA, 32, read data width
- W_RESP, 2, read response width
- W_PCS, 4, sub-burst count width; counts 1..2^W_PCS-1 are legal
- DEPTH, 8, info FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- info_valid  in  1  splitter has an original-AR record (asserted on original AR handshake)
- info_pcs  in  W_PCS  number of sub-bursts issued for that AR
- info_ready  out  1  FIFO can accept a record
- s_axi_rid  in  W_ID  slave read ID
- s_axi_rdata  in  W_DATA  slave read data
- s_axi_rresp  in  W_RESP  slave read response
- s_axi_rlast  in  1  last beat of a sub-burst
- s_axi_rvalid  in  1  slave beat valid
- s_axi_rready  out  1  accept slave beat
- m_axi_rid  out  W_ID  master read ID
- m_axi_rdata  out  W_DATA  master read data
- m_axi_rresp  out  W_RESP  master read response
- m_axi_rlast  out  1  last beat of the merged original burst
- m_axi_rvalid  out  1  master beat valid
- m_axi_rready  in  1  master accepts beat

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, wr/rd pointers 0, pcs_cnt=0, info_ready=1. All m_axi_* outputs 0 except payload, which passes through; s_axi_rready=0.
- Info FIFO:
  - Push on info_valid&info_ready.
  - info_ready = !full; registered count, not combinationally dependent on a same-cycle pop.
  - Stored value 0 is treated as 1.
  - Pointers are W=log2(DEPTH)+1 bits; full when MSBs differ and the rest are equal; wrap-around is natural.
- Gating: head record present (not empty) -> m_axi_rvalid = s_axi_rvalid and s_axi_rready = m_axi_rready.
- FIFO empty -> m_axi_rvalid=0 and s_axi_rready=0. Beats stall and no beat is dropped. No push-to-pop bypass: a record pushed in cycle N gates beats from cycle N+1.
- m_axi_rlast = s_axi_rlast & (pcs_cnt == head_pcs-1). Base path latency is 0 cycles.
- Beat transfer = s_axi_rvalid & s_axi_rready.
  - Transfer with s_axi_rlast and not final: pcs_cnt++.
  - Transfer with s_axi_rlast and final: pcs_cnt<=0, pop head.
  - Non-last beats leave state unchanged.
- Simultaneous push and pop when full: the pop happens and the push is refused (info_ready was 0). When neither full nor empty, both occur and the count is unchanged.
- Responses are in AR order (single outstanding ID order toward the slave); IDs are not checked.
- Reset mid-burst: state clears immediately. Outstanding slave beats after reset are the system's responsibility.

Optional Feature:
- Macro: CROSS_4K_RMERGE_REG_EN.
- When defined, a 2-entry skid register slice is placed on the master side. All m_axi_* outputs are registered, with +1 cycle latency and full throughput of 1 beat/cycle under continuous m_axi_rready. s_axi_rready = slice not full. The pcs_cnt/pop logic still acts at the slave-side transfer.
- When undefined: the combinational pass-through described above.

Test Plan:
- Push pcs=1; slave sends 4 beats, rlast on beat 4 -> master sees 4 beats, rlast on beat 4; FIFO empty after.
- Push pcs=2; slave sends 2 beats (rlast) then 3 beats (rlast) -> master sees 5 beats, rlast only on beat 5; pcs_cnt is 1 between sub-bursts.
- Slave rvalid=1 with FIFO empty for 3 cycles -> s_axi_rready=0, m_axi_rvalid=0; push pcs=1 -> beat passes on the following cycle.
- Push 8 records pcs=1 with no R traffic -> info_ready=0 after the 8th. Then complete 1 burst while info_valid=1 -> that push is refused in the pop cycle and accepted the next cycle.
- m_axi_rready toggling 1,0,1,0 during a pcs=3 burst of 1-beat sub-bursts -> no beat is lost or duplicated, rdata order is preserved, and rlast is only on the 3rd beat.
- Assert rst after the first sub-burst of a pcs=2 record -> next cycle FIFO is empty, pcs_cnt=0, s_axi_rready=0.
